alu_dot_seq: RTL and testbench

- Sequencer that drives the 5-operand ALU (result = a*b + c*d + e).
- Accepts a command of N operand beats and feeds one beat per pass, with the running accumulator as operand e.
- Returns the final accumulated value over a valid/ready result port.
- Sits between the instruction/control path and the ALU instance; it is the only driver of the ALU's ops, reg_en and f_add.

---
 rtl/alu_dot_seq.sv | 113 +++++++++++
 tb/tb_alu_dot_seq.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_dot_seq.sv
// Sequencer for the 5-operand ALU (result = a*b + c*d + e).
// Each operand beat is one ALU pass, and the running accumulator is fed back as operand e.
module alu_dot_seq #(
  parameter int BUS_WIDTH = 8,
  parameter int LEN_WIDTH = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          cmd_valid_i,
  output logic                          cmd_ready_o,
  input  logic                          cmd_mode_i,
  input  logic [LEN_WIDTH-1:0]          cmd_len_i,
  input  logic [BUS_WIDTH-1:0]          cmd_seed_i,
  input  logic                          in_valid_i,
  output logic                          in_ready_o,
  input  logic [3:0][BUS_WIDTH-1:0]     in_ops_i,
  output logic                          res_valid_o,
  input  logic                          res_ready_i,
  output logic [BUS_WIDTH-1:0]          res_data_o,
  output logic [4:0][BUS_WIDTH-1:0]     alu_ops_o,
  output logic [4:0]                    alu_reg_en_o,
  output logic                          alu_f_add_o,
  input  logic [BUS_WIDTH-1:0]          alu_result_i
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    EXEC,
    DONE
  } state_e;

  localparam logic [BUS_WIDTH-1:0] ONE      = BUS_WIDTH'(1);
  localparam logic [LEN_WIDTH-1:0] LAST_CNT = LEN_WIDTH'(1);

  state_e               state_q, state_d;
  logic [BUS_WIDTH-1:0] acc_q,   acc_d;
  logic [LEN_WIDTH-1:0] count_q, count_d;
  logic                 mode_q,  mode_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      acc_q   <= '0;
      count_q <= '0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      count_q <= count_d;
      mode_q  <= mode_d;
    end
  end

  // The ALU registers capture on the LOAD handshake edge, so its result is ready to fold into acc during EXEC.
  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    count_d      = count_q;
    mode_d       = mode_q;
    cmd_ready_o  = 1'b0;
    in_ready_o   = 1'b0;
    res_valid_o  = 1'b0;
    res_data_o   = '0;
    alu_reg_en_o = '0;

    case (state_q)
      IDLE: begin
        cmd_ready_o = 1'b1;
        if (cmd_valid_i) begin
          mode_d  = cmd_mode_i;
          count_d = cmd_len_i;
          acc_d   = cmd_seed_i;
          state_d = (cmd_len_i != '0) ? LOAD : DONE;
        end
      end
      LOAD: begin
        in_ready_o = 1'b1;
        if (in_valid_i) begin
          alu_reg_en_o = '1;
          state_d      = EXEC;
        end
      end
      EXEC: begin
        acc_d   = alu_result_i;
        count_d = count_q - LAST_CNT;
        state_d = (count_q == LAST_CNT) ? DONE : LOAD;
      end
      DONE: begin
        res_valid_o = 1'b1;
        res_data_o  = acc_q;
        if (res_ready_i) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // In SUM mode, the multiplier operands b and d are forced to 1, so the ALU computes a + c + acc.
  always_comb begin
    alu_ops_o[0] = in_ops_i[0];
    alu_ops_o[1] = mode_q ? ONE : in_ops_i[1];
    alu_ops_o[2] = in_ops_i[2];
    alu_ops_o[3] = mode_q ? ONE : in_ops_i[3];
    alu_ops_o[4] = acc_q;
  end

  assign alu_f_add_o = 1'b0;

endmodule

// File: tb/tb_alu_dot_seq.sv
// Randomized scoreboard bench for alu_dot_seq, with a behavioural ALU attached.
// Expected results come from plain arithmetic over the beats of each command.
module tb_alu_dot_seq;

  logic            clk = 1'b0;
  logic            rst;
  logic            cmdValid, cmdReady, cmdMode;
  logic [3:0]      cmdLen;
  logic [7:0]      cmdSeed;
  logic            inValid, inReady;
  logic [3:0][7:0] inOps;
  logic            resValid, resReady;
  logic [7:0]      resData;
  logic [4:0][7:0] aluOps;
  logic [4:0]      aluRegEn;
  logic            aluFAdd;
  logic [7:0]      aluResult;

  int        checks = 0;
  int        errors = 0;
  int        cyc = 0;
  int        acceptCyc = 0;
  int        resCyc = -1;
  int        resHsCyc = 0;
  logic [31:0] regEnLog = '0;
  bit        inReadySeen = 1'b0;
  bit        curMode = 1'b0;
  bit        randReady = 1'b0;
  logic [7:0] lastRes = '0;
  logic [7:0] expQ[$];
  logic [7:0] bA[16], bB[16], bC[16], bD[16];
  logic [7:0] aluRegs[5];

  alu_dot_seq #(.BUS_WIDTH(8), .LEN_WIDTH(4)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .cmd_valid_i(cmdValid),
    .cmd_ready_o(cmdReady),
    .cmd_mode_i(cmdMode),
    .cmd_len_i(cmdLen),
    .cmd_seed_i(cmdSeed),
    .in_valid_i(inValid),
    .in_ready_o(inReady),
    .in_ops_i(inOps),
    .res_valid_o(resValid),
    .res_ready_i(resReady),
    .res_data_o(resData),
    .alu_ops_o(aluOps),
    .alu_reg_en_o(aluRegEn),
    .alu_f_add_o(aluFAdd),
    .alu_result_i(aluResult)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural ALU: operand registers capture on reg_en; the result is combinational from the registers.
  always @(posedge clk) begin
    for (int i = 0; i < 5; i++) begin
      if (aluRegEn[i]) aluRegs[i] <= aluOps[i];
    end
  end
  assign aluResult = aluRegs[0] * aluRegs[1] + aluRegs[2] * aluRegs[3] + aluRegs[4];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h (time %0t)", name, actual, expected, $time);
    end
  endtask

  // Monitor: logs per-command timing and pops the scoreboard on each result handshake.
  always @(negedge clk) begin
    if (!rst) begin
      if (cmdValid && cmdReady) begin
        acceptCyc   = cyc;
        regEnLog    = '0;
        resCyc      = -1;
        inReadySeen = 1'b0;
      end else begin
        if (inReady) inReadySeen = 1'b1;
        if (aluRegEn == 5'h1f && (cyc - acceptCyc) >= 0 && (cyc - acceptCyc) < 32)
          regEnLog[cyc - acceptCyc] = 1'b1;
        if (resValid && resCyc < 0) resCyc = cyc - acceptCyc;
        if (curMode && aluRegEn == 5'h1f) begin
          checkOutput("sumOpB", {24'd0, aluOps[1]}, 32'd1);
          checkOutput("sumOpD", {24'd0, aluOps[3]}, 32'd1);
        end
      end
      if (resValid && resReady) begin
        resHsCyc = cyc;
        lastRes  = resData;
        if (expQ.size() == 0) checkOutput("scoreboardUnderflow", 32'd1, 32'd0);
        else checkOutput("resData", {24'd0, resData}, {24'd0, expQ.pop_front()});
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (randReady) resReady = ($urandom % 3) != 0;
    end
  end

  task automatic applyStimulus(input bit mode, input int len, input logic [7:0] seed, input int gap);
    int expVal;
    bit ok;
    expVal = int'($signed(seed));
    for (int i = 0; i < len; i++) begin
      if (mode)
        expVal += int'($signed(bA[i])) + int'($signed(bC[i]));
      else
        expVal += int'($signed(bA[i])) * int'($signed(bB[i])) + int'($signed(bC[i])) * int'($signed(bD[i]));
    end
    expQ.push_back(8'(expVal));
    curMode  = mode;
    cmdValid = 1'b1;
    cmdMode  = mode;
    cmdLen   = 4'(len);
    cmdSeed  = seed;
    ok = 1'b0;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (cmdReady) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    cmdValid = 1'b0;
    if (!ok) begin
      checkOutput("cmdAcceptTimeout", 32'd0, 32'd1);
      return;
    end
    for (int i = 0; i < len; i++) begin
      if (i > 0 && gap > 0) begin
        inValid = 1'b0;
        repeat (gap) @(posedge clk);
        #1;
      end
      inValid = 1'b1;
      inOps   = {bD[i], bC[i], bB[i], bA[i]};
      ok = 1'b0;
      for (int t = 0; t < 300; t++) begin
        @(negedge clk);
        if (inReady) begin
          ok = 1'b1;
          break;
        end
      end
      @(posedge clk);
      #1;
      if (!ok) begin
        inValid = 1'b0;
        checkOutput("beatAcceptTimeout", 32'd0, 32'd1);
        return;
      end
    end
    inValid = 1'b0;
  endtask

  task automatic waitDrain(input string name);
    for (int t = 0; t < 2000; t++) begin
      @(posedge clk);
      if (expQ.size() == 0) break;
    end
    #1;
    checkOutput(name, expQ.size(), 32'd0);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "CmdReady"}, {31'd0, cmdReady}, 32'd1);
    checkOutput({tag, "InReady"},  {31'd0, inReady},  32'd0);
    checkOutput({tag, "ResValid"}, {31'd0, resValid}, 32'd0);
    checkOutput({tag, "ResData"},  {24'd0, resData},  32'd0);
    checkOutput({tag, "RegEn"},    {27'd0, aluRegEn}, 32'd0);
    checkOutput({tag, "FAdd"},     {31'd0, aluFAdd},  32'd0);
    checkOutput({tag, "AccOp"},    {24'd0, aluOps[4]}, 32'd0);
  endtask

  initial begin
    logic [7:0] held;
    rst = 1'b1;
    cmdValid = 1'b0; cmdMode = 1'b0; cmdLen = '0; cmdSeed = '0;
    inValid = 1'b0; inOps = '0; resReady = 1'b1;
    #1;
    checkResetOutputs("reset");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // MAC directed: 3*4+5*6 = 42, then 2*2+1*1+42 = 47
    bA[0] = 8'd3; bB[0] = 8'd4; bC[0] = 8'd5; bD[0] = 8'd6;
    bA[1] = 8'd2; bB[1] = 8'd2; bC[1] = 8'd1; bD[1] = 8'd1;
    applyStimulus(1'b0, 2, 8'd0, 0);
    waitDrain("macDrain");
    checkOutput("macResult", {24'd0, lastRes}, 32'd47);
    checkOutput("macResCycle", resCyc, 32'd5);
    checkOutput("macRegEnCycles", regEnLog, 32'b1010);

    // Wrap: 100 + 30 = 130 wraps to 0x82
    bA[0] = 8'd10; bB[0] = 8'd10; bC[0] = 8'd10; bD[0] = 8'd3;
    applyStimulus(1'b0, 1, 8'd0, 0);
    waitDrain("wrapDrain");
    checkOutput("wrapResult", {24'd0, lastRes}, 32'h82);

    // SUM: 10 + 3 + 7 - 5 = 15, with b/d driven to 7 but forced to 1
    bA[0] = 8'd1;   bC[0] = 8'd2; bA[1] = 8'd3; bC[1] = 8'd4;
    bA[2] = 8'hfb;  bC[2] = 8'd0;
    for (int i = 0; i < 3; i++) begin
      bB[i] = 8'd7;
      bD[i] = 8'd7;
    end
    applyStimulus(1'b1, 3, 8'd10, 0);
    waitDrain("sumDrain");
    checkOutput("sumResult", {24'd0, lastRes}, 32'd15);

    // Zero-length command returns the seed one cycle after acceptance
    applyStimulus(1'b0, 0, 8'd7, 0);
    waitDrain("zeroDrain");
    checkOutput("zeroResult", {24'd0, lastRes}, 32'd7);
    checkOutput("zeroResCycle", resCyc, 32'd1);
    checkOutput("zeroInReady", {31'd0, inReadySeen}, 32'd0);
    checkOutput("zeroRegEn", regEnLog, 32'd0);

    // Backpressure: beat gaps, then a stalled result with the next command waiting
    resReady = 1'b0;
    for (int i = 0; i < 16; i++) begin
      bA[i] = 8'($urandom); bB[i] = 8'($urandom); bC[i] = 8'($urandom); bD[i] = 8'($urandom);
    end
    applyStimulus(1'b0, 2, 8'($urandom), 3);
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (resValid) break;
    end
    checkOutput("bpResValid", {31'd0, resValid}, 32'd1);
    held = resData;
    @(posedge clk);
    #1;
    bA[0] = 8'($urandom); bC[0] = 8'($urandom);
    fork
      applyStimulus(1'b1, 1, 8'($urandom), 0);
      begin
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          checkOutput("bpHoldData", {24'd0, resData}, {24'd0, held});
          checkOutput("bpCmdReady", {31'd0, cmdReady}, 32'd0);
        end
        @(posedge clk);
        #1;
        resReady = 1'b1;
      end
    join
    checkOutput("bpAcceptAfterHs", acceptCyc - resHsCyc, 32'd1);
    waitDrain("bpDrain");

    // Reset during the EXEC of beat 2 of 3
    curMode = 1'b0;
    cmdValid = 1'b1; cmdMode = 1'b0; cmdLen = 4'd3; cmdSeed = 8'd9;
    @(negedge clk);
    checkOutput("rstCmdReady", {31'd0, cmdReady}, 32'd1);
    @(posedge clk);
    #1;
    cmdValid = 1'b0;
    inValid  = 1'b1;
    inOps    = {8'd1, 8'd2, 8'd3, 8'd4};
    repeat (3) @(posedge clk);
    #1;
    inValid = 1'b0;
    inOps   = '0;
    checkOutput("rstPreInReady", {31'd0, inReady}, 32'd0);
    rst = 1'b1;
    #1;
    checkResetOutputs("midReset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    bA[0] = 8'd1; bB[0] = 8'd1; bC[0] = 8'd0; bD[0] = 8'd0;
    applyStimulus(1'b0, 1, 8'd0, 0);
    waitDrain("postRstDrain");
    checkOutput("postRstResult", {24'd0, lastRes}, 32'd1);

    // Randomized commands with random result backpressure
    randReady = 1'b1;
    for (int n = 0; n < 30; n++) begin
      for (int i = 0; i < 16; i++) begin
        bA[i] = 8'($urandom); bB[i] = 8'($urandom); bC[i] = 8'($urandom); bD[i] = 8'($urandom);
      end
      applyStimulus(1'($urandom % 2), int'($urandom_range(0, 6)), 8'($urandom), int'($urandom_range(0, 2)));
    end
    waitDrain("randDrain");
    randReady = 1'b0;
    resReady  = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
